// File: rtl/gpio_irq_srv.sv
// gpio_irq_srv
//   Owns the gpio register bus and shares it between a host master and an
//   internal interrupt-service engine. On gpio irq the engine reads the
//   interrupt vector, clears it, and queues non-zero vectors in an event FIFO.
//   The host therefore never has to poll the vector register.
//
// Ports
//   clk, rstn                 clock (rising edge), async active-low reset
//   h_req/h_addr/h_we/h_wd    host request; fields held stable until h_gnt
//   h_gnt, h_rd               host grant (combinational) and read data
//   p_addr/p_we/p_wd          gpio bus outputs
//   p_rd, p_irq               gpio read data (combinational) and interrupt
//   ev_valid/ev_data/ev_ready event FIFO head and pop handshake
//   ev_cnt                    event FIFO occupancy
module gpio_irq_srv #(
  parameter int          gpio_w   = 8,
  parameter int          FIFO_D   = 4,
  parameter logic [31:0] VEC_ADDR = 32'h14,
  parameter int          HOLDOFF  = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      h_req,
  input  logic [31:0]               h_addr,
  input  logic                      h_we,
  input  logic [31:0]               h_wd,
  output logic                      h_gnt,
  output logic [31:0]               h_rd,
  output logic [31:0]               p_addr,
  output logic                      p_we,
  output logic [31:0]               p_wd,
  input  logic [31:0]               p_rd,
  input  logic                      p_irq,
  output logic                      ev_valid,
  output logic [gpio_w-1:0]         ev_data,
  input  logic                      ev_ready,
  output logic [$clog2(FIFO_D):0]   ev_cnt
);

  localparam int PW = $clog2(FIFO_D);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(HOLDOFF + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_VEC  = 2'd1;
  localparam logic [1:0] CLR_VEC = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  localparam logic SVC  = 1'b0;
  localparam logic HOST = 1'b1;

  logic [1:0]        state, state_nxt;
  logic              last_owner, last_owner_nxt;
  logic [HW-1:0]     hold_cnt;
  logic [gpio_w-1:0] vec_r;

  logic [gpio_w-1:0] mem [FIFO_D];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;

  logic full, svc_wins, push, pop;

  assign full     = (count == CW'(FIFO_D));
  // Round-robin: service yields to a waiting host only if it owned the bus last.
  assign svc_wins = p_irq && !full && (!h_req || (last_owner == HOST));

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    h_gnt          = 1'b0;
    h_rd           = '0;
    p_addr         = '0;
    p_we           = 1'b0;
    p_wd           = '0;
    case (state)
      IDLE: begin
        if (svc_wins) begin
          state_nxt      = RD_VEC;
          last_owner_nxt = SVC;
        end else if (h_req) begin
          h_gnt          = 1'b1;
          p_addr         = h_addr;
          p_we           = h_we;
          p_wd           = h_wd;
          h_rd           = p_rd;
          last_owner_nxt = HOST;
        end
      end
      RD_VEC: begin
        p_addr    = VEC_ADDR;
        state_nxt = CLR_VEC;
      end
      CLR_VEC: begin
        p_addr    = VEC_ADDR;
        p_we      = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (hold_cnt <= HW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Outputs must read zero the moment reset asserts, even in IDLE with h_req up.
    if (!rstn) begin
      h_gnt  = 1'b0;
      h_rd   = '0;
      p_addr = '0;
      p_we   = 1'b0;
      p_wd   = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      last_owner <= SVC;
      hold_cnt   <= '0;
      vec_r      <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      if (state_nxt == HOLD && state != HOLD) hold_cnt <= HW'(HOLDOFF);
      else if (state == HOLD)                 hold_cnt <= hold_cnt - HW'(1);
      if (state == RD_VEC) vec_r <= p_rd[gpio_w-1:0];
    end
  end

  // A zero vector means the irq was spurious, so nothing is queued for it.
  assign push = (state == CLR_VEC) && (vec_r != '0) && (!full || pop);
  assign pop  = (count != '0) && ev_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_D; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= vec_r;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign ev_valid = (count != '0);
  assign ev_data  = ev_valid ? mem[rd_ptr] : '0;
  assign ev_cnt   = count;

endmodule
